// File: rtl/sdf_output_reorder_if.sv
// ---------------------------------------------------------------------------
// sdf_output_reorder_if
//
// Sample-stream bundle for the FFT output reorder buffer.
//   di_en          : input sample valid (one sample per cycle when high)
//   di_re / di_im  : input sample, real / imaginary, two's complement
//   do_en          : output sample valid
//   do_re / do_im  : output sample, real / imaginary
//   do_last        : marks the final (index N-1) sample of each output frame
//
// Modports:
//   master : the side that produces input samples and consumes output
//   slave  : the reorder buffer itself
// ---------------------------------------------------------------------------
interface sdf_output_reorder_if #(
    parameter int WIDTH = 16
) ();
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;

    modport master (
        output di_en,
        output di_re,
        output di_im,
        input  do_en,
        input  do_re,
        input  do_im,
        input  do_last
    );

    modport slave (
        input  di_en,
        input  di_re,
        input  di_im,
        output do_en,
        output do_re,
        output do_im,
        output do_last
    );
endinterface

// File: rtl/sdf_output_reorder.sv
// ---------------------------------------------------------------------------
// sdf_output_reorder
//
// Reorder buffer behind the last radix-2 SDF stage of the pipelined FFT.
// Frames arrive in bit-reversed order and leave in natural order. Two
// ping-pong banks of N complex samples let one frame be written while the
// previous one streams out as an unbroken N-cycle burst.
//
// Ports:
//   clock : master clock, rising edge
//   reset : synchronous, active-high
//   bus   : sdf_output_reorder_if.slave (di_en/di_re/di_im in,
//           do_en/do_re/do_im/do_last out)
//
// Parameters:
//   WIDTH : bits per real/imag component
//   LOG_N : log2 of the FFT length (>= 2)
// ---------------------------------------------------------------------------
module sdf_output_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic                clock,
    input  logic                reset,
    sdf_output_reorder_if.slave bus
);

    localparam int               N        = 2 ** LOG_N;
    localparam logic [LOG_N-1:0] LAST_IDX = {LOG_N{1'b1}};
    localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    // Both banks live in one array; the bank select is the top address bit.
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    logic [LOG_N-1:0]   wcnt;
    logic               wbank;
    logic [1:0]         full;
    logic [1:0]         full_next;
    logic               start;

    logic [0:0]         state;
    logic [LOG_N-1:0]   rcnt;
    logic               rbank;
    logic [2*WIDTH-1:0] rdata;
    logic               out_en;
    logic               out_last;

    logic               wr_wrap;
    logic               rd_final;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    assign wr_wrap  = bus.di_en && (wcnt == LAST_IDX);
    assign rd_final = (state == READ) && (rcnt == LAST_IDX);

    // Incoming samples land at their natural-order slot, so the read side
    // can simply walk addresses 0..N-1.
    always_ff @(posedge clock) begin
        if (!reset && bus.di_en) begin
            mem[{wbank, bitrev(wcnt)}] <= {bus.di_re, bus.di_im};
        end
    end

    // Set wins over clear: a clear always targets the bank being drained,
    // which is never the bank that completes in the same cycle.
    always_comb begin
        full_next = full;
        if (rd_final) begin
            full_next[rbank] = 1'b0;
        end
        if (wr_wrap) begin
            full_next[wbank] = 1'b1;
        end
    end

    // Write-side bookkeeping. start is a one-cycle pulse issued on the edge
    // that accepts the last sample of a frame; by then wbank already points
    // at the other bank, so the finished bank is ~wbank while start is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
            start <= 1'b0;
        end else begin
            full  <= full_next;
            start <= wr_wrap;
            if (bus.di_en) begin
                wcnt <= wcnt + ONE;
            end
            if (wr_wrap) begin
                wbank <= ~wbank;
            end
        end
    end

    // Read FSM. When a new frame completes exactly on the last read of the
    // current one, the reader switches banks without passing through IDLE so
    // back-to-back frames come out with no gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rcnt     <= '0;
            rbank    <= 1'b0;
            out_en   <= 1'b0;
            out_last <= 1'b0;
        end else begin
            out_en   <= (state == READ);
            out_last <= rd_final;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        rbank <= ~wbank;
                        rcnt  <= '0;
                    end
                end
                READ: begin
                    rcnt <= rcnt + ONE;
                    if (rcnt == LAST_IDX) begin
                        if (start) begin
                            rbank <= ~wbank;
                            rcnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Synchronous read; this register is also the output data register, so
    // it lines up with out_en/out_last one cycle after the address.
    always_ff @(posedge clock) begin
        if (state == READ) begin
            rdata <= mem[{rbank, rcnt}];
        end
    end

    // A write into the bank being drained is only legal on the final read
    // cycle (it then hits address 0 while the reader is at N-1).
    always_ff @(posedge clock) begin
        if (!reset && bus.di_en && (state == READ) && (rbank == wbank) && !rd_final) begin
            overflow_check: assert (!full[wbank]);
        end
    end

    assign bus.do_en   = out_en;
    assign bus.do_last = out_last;
    assign bus.do_re   = rdata[2*WIDTH-1:WIDTH];
    assign bus.do_im   = rdata[WIDTH-1:0];

endmodule

// File: doc/sdf_output_reorder.md
# sdf_output_reorder

Frame reorder buffer that sits directly downstream of the final radix-2 SDF stage of the pipelined FFT. It accepts complete FFT frames in bit-reversed order and emits them in natural order. Two ping-pong banks of N complex samples each let frame f+1 be written while frame f streams out. Output is a continuous N-cycle burst per frame with an end-of-frame marker.

## Interface
- WIDTH, 16, bit width of each real/imag sample (two's complement)
- LOG_N, 6, log2 of FFT length; N = 2**LOG_N (minimum LOG_N = 2)
- clock  input  1  master clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset (one clock; sampled on rising edge)
- di_en  input  1  input sample valid; one sample accepted per cycle when high
- di_re  input  WIDTH  input sample, real
- di_im  input  WIDTH  input sample, imag
- do_en  output  1  output sample valid
- do_re  output  WIDTH  output sample, real
- do_im  output  WIDTH  output sample, imag
- do_last  output  1  high with do_en on the last (index N-1) sample of each output frame

## Operation
- Storage: two banks, each N × 2·WIDTH, with synchronous read; contents are not reset.
- Write side:
  - LOG_N-bit write counter wcnt and 1-bit write-bank pointer wbank.
  - On each cycle with di_en=1, write {di_re,di_im} to bank wbank at address bitrev(wcnt), then increment wcnt.
  - Gaps (di_en=0) are allowed anywhere; wcnt holds during a gap.
  - When wcnt wraps N-1→0: set full[wbank], toggle wbank, and raise a one-cycle start pulse to the read side.
- Read side FSM, states IDLE and READ:
  - IDLE→READ on the start pulse: rbank ← just-completed bank; rcnt ← 0.
  - READ: one read per cycle at natural address rcnt from bank rbank; rcnt increments.
  - At rcnt = N-1: clear full[rbank]. If another start pulse is pending in that same cycle, stay in READ with the new bank and rcnt ← 0 (seamless back-to-back frames). Otherwise go to IDLE.
- Outputs:
  - do_en, do_last, do_re and do_im are registered from the read pipeline.
  - Output index k carries the input sample whose arrival index was bitrev(k).
  - Data passes through bit-exact; no arithmetic, scaling or rounding.
- No backpressure. The reader drains N samples in N cycles and the writer needs at least N cycles per frame, so overflow cannot occur by construction. Verification asserts that a write never targets a bank with full=1 while it is being read.
- Reset (any time, including mid-frame or mid-read):
  - wcnt=0, wbank=0, full=0, FSM=IDLE, do_en=0, do_last=0.
  - Any partially written frame and any in-flight read are discarded.
  - do_re/do_im are don't-care after reset; the bench must not check them while do_en=0.

## Timing
- Reset values: do_en=0, do_last=0; do_re/do_im undefined until the first valid output.
- Latency: if the last sample (wcnt=N-1) of a frame is accepted at edge T, then:
  - do_en rises at edge T+2 with output index 0;
  - do_en stays high for exactly N consecutive cycles;
  - do_last is high only on the Nth of those cycles.
- Back-to-back input frames with di_en held high continuously produce continuous do_en with no gap between output frames.
- Gapped input delays only the frame-complete edge T; the output burst itself is never gapped.
- A simultaneous last-write of frame f+1 and last-read of frame f is handled by the seamless transition described under Operation.
- Reset asserted at edge R: do_en=0 from edge R onward. A new frame may begin with di_en at edge R+1.

## Test plan
- Single frame, N=64, di_re=j, di_im=-j for arrival j=0..63 contiguous -> do_re = 0,32,16,48,8,40,… (bitrev(k)), do_im = -bitrev(k); do_en high 64 cycles starting 2 cycles after the last input; do_last only on k=63.
- Four frames back-to-back with di_en held high, frame f data = 256·f + j -> 256 contiguous do_en cycles; each 64-sample burst is correct for its frame; do_last on cycles 63, 127, 191, 255.
- Random di_en gaps (≈50% duty) over 3 frames -> output identical to the contiguous case; each burst is an unbroken 64 cycles; latency measured from the last accepted sample = 2.
- Reset asserted after 40 samples of frame 0, then a full frame 1 -> no output for frame 0; frame 1 output correct, starting at address 0.
- Reset asserted mid-output (during k=20) -> do_en=0 on the next cycle; the following frame is output fully and correctly.
- Extremes: di_re=32767/-32768, di_im=-32768/32767 alternating -> values pass through bit-exact in reordered positions.
